// File: rtl/scope_pkg.sv
// Shared constants for the capture/trigger scope: FSM state encoding and default widths.
package scope_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 9;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_POST = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (1-cycle latency), no reset.
module capture_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/capture_trigger.sv
// Pre/post-trigger sample capture into a ring buffer with oldest-first readout.
// Optional CAPTURE_DECIM_EN adds a decim input that stores only every (decim+1)-th sample.
module capture_trigger
   import scope_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned PRE_TRIG = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              arm,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic              rd_req,
`ifdef CAPTURE_DECIM_EN
   input  logic [7:0]        decim,
`endif
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   output logic [2:0]        state_o,
   output logic              done
);

   localparam int unsigned N     = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] PRE_LEN  = ADDR_W'(PRE_TRIG);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
   localparam logic [CNT_W-1:0]  POST_LEN = CNT_W'(N - PRE_TRIG);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              prev_vld_q, prev_vld_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;
   logic              done_q, done_d;

   logic              stb_c;
   logic              arm_ok_c;
   logic              wr_en_c;
   logic              rd_accept_c;
   logic              trig_hit_c;
   logic [DATA_W-1:0] ram_rdata;

   assign arm_ok_c = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign wr_en_c  = stb_c && ((state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST));
   // Last read is in flight while rd_last_q is high; further requests are dropped.
   assign rd_accept_c = (state_q == ST_DONE) && rd_req && !arm && !rd_last_q;

`ifdef CAPTURE_DECIM_EN
   logic [7:0] dec_cnt_q, dec_cnt_d;

   assign stb_c = (dec_cnt_q == 8'd0);

   always_comb begin
      dec_cnt_d = dec_cnt_q + 8'd1;
      if (arm_ok_c || (dec_cnt_q == decim)) dec_cnt_d = 8'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dec_cnt_q <= 8'd0;
      else     dec_cnt_q <= dec_cnt_d;
   end
`else
   assign stb_c = 1'b1;
`endif

   // Level crossing relative to the previously stored sample.
   always_comb begin
      trig_hit_c = 1'b0;
      if (prev_vld_q) begin
         if (trig_rising) trig_hit_c = (prev_q < trig_level) && (sample_in >= trig_level);
         else             trig_hit_c = (prev_q >= trig_level) && (sample_in < trig_level);
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      pre_cnt_d  = pre_cnt_q;
      post_cnt_d = post_cnt_q;
      start_d    = start_q;
      rd_cnt_d   = rd_cnt_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      rd_valid_d = rd_accept_c;
      rd_last_d  = rd_accept_c && (rd_cnt_q == LAST_IDX);

      if (wr_en_c) begin
         wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
         prev_d     = sample_in;
         prev_vld_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: ;
         ST_PRE: begin
            if (stb_c) begin
               pre_cnt_d = pre_cnt_q + ADDR_W'(1);
               if (pre_cnt_q + ADDR_W'(1) == PRE_LEN) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (stb_c && trig_hit_c) begin
               start_d    = wr_ptr_q - PRE_LEN;
               post_cnt_d = CNT_W'(1);
               state_d    = (POST_LEN == CNT_W'(1)) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            if (stb_c) begin
               post_cnt_d = post_cnt_q + CNT_W'(1);
               if (post_cnt_q + CNT_W'(1) == POST_LEN) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (rd_accept_c) rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            if (rd_last_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Arm restarts from IDLE or DONE; it overrides any read in the same cycle.
      if (arm_ok_c) begin
         state_d    = (PRE_TRIG == 0) ? ST_WAIT : ST_PRE;
         wr_ptr_d   = '0;
         pre_cnt_d  = '0;
         post_cnt_d = '0;
         rd_cnt_d   = '0;
         prev_vld_d = 1'b0;
      end

      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         start_q    <= '0;
         rd_cnt_q   <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         pre_cnt_q  <= pre_cnt_d;
         post_cnt_q <= post_cnt_d;
         start_q    <= start_d;
         rd_cnt_q   <= rd_cnt_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         done_q     <= done_d;
      end
   end

   capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (sample_in),
      .rd_en_i   (rd_accept_c),
      .rd_addr_i (start_q + rd_cnt_q),
      .rd_data_o (ram_rdata)
   );

   // RAM output has no reset; present zero whenever no read is being returned.
   assign rd_data  = rd_valid_q ? ram_rdata : '0;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign state_o  = state_q;
   assign done     = done_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Three 16-deep capture_trigger instances (pre-trigger 4, 0, 6) driven by one stimulus stream,
// checked against a sample-list reference model.
module tb_capture_trigger;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sample_in;
   logic       arm;
   logic [7:0] trig_level;
   logic       trig_rising;
   logic       rd_req;
`ifdef CAPTURE_DECIM_EN
   logic [7:0] decim;
`endif

   logic [2:0][7:0] rdd;
   logic [2:0]      rdv, rdl, dn;
   logic [2:0][2:0] st;

   int n_asserts = 0;
   int n_fail    = 0;
   int dec_r     = 0;
   logic [7:0] stim[$];
   logic [7:0] expq[3][N];

   always #5 clk = ~clk;

   capture_trigger #(.DATA_W(8), .ADDR_W(4), .PRE_TRIG(4)) u_dut0 (
      .clk(clk), .rst(rst), .sample_in(sample_in), .arm(arm), .trig_level(trig_level),
      .trig_rising(trig_rising), .rd_req(rd_req),
`ifdef CAPTURE_DECIM_EN
      .decim(decim),
`endif
      .rd_data(rdd[0]), .rd_valid(rdv[0]), .rd_last(rdl[0]), .state_o(st[0]), .done(dn[0]));

   capture_trigger #(.DATA_W(8), .ADDR_W(4), .PRE_TRIG(0)) u_dut1 (
      .clk(clk), .rst(rst), .sample_in(sample_in), .arm(arm), .trig_level(trig_level),
      .trig_rising(trig_rising), .rd_req(rd_req),
`ifdef CAPTURE_DECIM_EN
      .decim(decim),
`endif
      .rd_data(rdd[1]), .rd_valid(rdv[1]), .rd_last(rdl[1]), .state_o(st[1]), .done(dn[1]));

   capture_trigger #(.DATA_W(8), .ADDR_W(4), .PRE_TRIG(6)) u_dut2 (
      .clk(clk), .rst(rst), .sample_in(sample_in), .arm(arm), .trig_level(trig_level),
      .trig_rising(trig_rising), .rd_req(rd_req),
`ifdef CAPTURE_DECIM_EN
      .decim(decim),
`endif
      .rd_data(rdd[2]), .rd_valid(rdv[2]), .rd_last(rdl[2]), .state_o(st[2]), .done(dn[2]));

   function automatic int pre_of(input int g);
      case (g)
         0:       return 4;
         1:       return 0;
         default: return 6;
      endcase
   endfunction

   function automatic bit crossing(input logic [7:0] a, input logic [7:0] b);
      if (trig_rising) return (a < trig_level) && (b >= trig_level);
      else             return (a >= trig_level) && (b < trig_level);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s inst%0d: observed %0h expected %0h", tag, g, obs, exp);
      end
   endtask

   // Model: list of stored samples, first legal crossing, then the N-sample window around it.
   task automatic build_model(input string tag);
      logic [7:0] stored[$];
      int k, p;
      for (int i = 0; i < stim.size(); i++)
         if (i % (dec_r + 1) == 0) stored.push_back(stim[i]);
      for (int g = 0; g < 3; g++) begin
         p = pre_of(g);
         k = -1;
         for (int i = (p > 0) ? p : 1; i < stored.size() && k < 0; i++)
            if (crossing(stored[i-1], stored[i])) k = i;
         if (k < 0 || k - p + N > stored.size()) begin
            n_fail++;
            $display("FAIL %s inst%0d: stimulus has no usable trigger", tag, g);
         end else begin
            for (int i = 0; i < N; i++) expq[g][i] = stored[k - p + i];
         end
      end
   endtask

   task automatic run(input string tag, input int arm_again_at);
      int j;
      build_model(tag);
      arm = 1'b1;
      sample_in = 8'h00;
      step();
      arm = 1'b0;
      j = 0;
      while (!(&dn) && j < stim.size() + 20) begin
         sample_in = (j < stim.size()) ? stim[j] : 8'h00;
         arm = (j == arm_again_at);
         step();
         j++;
      end
      arm = 1'b0;
      check({tag, "_all_done"}, 0, 32'(&dn), 32'd1);
      for (int i = 0; i < N; i++) begin
         rd_req = 1'b1;
         step();
         for (int g = 0; g < 3; g++) begin
            check({tag, "_rd_valid"}, g, 32'(rdv[g]), 32'd1);
            check({tag, "_rd_data"}, g, 32'(rdd[g]), 32'(expq[g][i]));
            check({tag, "_rd_last"}, g, 32'(rdl[g]), 32'(i == N - 1));
         end
      end
      rd_req = 1'b0;
      step();
      for (int g = 0; g < 3; g++) begin
         check({tag, "_idle_after"}, g, 32'(st[g]), 32'd0);
         check({tag, "_done_low"}, g, 32'(dn[g]), 32'd0);
         check({tag, "_no_extra_valid"}, g, 32'(rdv[g]), 32'd0);
      end
   endtask

   initial begin
      int j;
      rst = 1'b1;
      arm = 1'b0;
      rd_req = 1'b0;
      sample_in = 8'h00;
      trig_level = 8'h00;
      trig_rising = 1'b1;
`ifdef CAPTURE_DECIM_EN
      decim = 8'd0;
`endif
      step();
      step();
      for (int g = 0; g < 3; g++) begin
         check("reset_state", g, 32'(st[g]), 32'd0);
         check("reset_done", g, 32'(dn[g]), 32'd0);
         check("reset_rd_valid", g, 32'(rdv[g]), 32'd0);
         check("reset_rd_last", g, 32'(rdl[g]), 32'd0);
         check("reset_rd_data", g, 32'(rdd[g]), 32'd0);
      end
      rst = 1'b0;
      step();

      // Read request while idle must be ignored.
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      for (int g = 0; g < 3; g++) check("idle_rd_req", g, 32'(rdv[g]), 32'd0);
      step();

      // Ramp, rising at 20, with a stray arm during WAIT.
      stim.delete();
      for (int i = 0; i < 100; i++) stim.push_back(8'(i));
      trig_level = 8'd20;
      trig_rising = 1'b1;
      run("ramp", 10);

      // Falling at 0x80: 0x80 alone is not a crossing, the following 0x7F is.
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back(8'hFF);
      stim.push_back(8'h80);
      stim.push_back(8'h7F);
      for (int i = 0; i < 30; i++) stim.push_back(8'(8'h20 + i));
      trig_level = 8'h80;
      trig_rising = 1'b0;
      run("falling", -1);

      // First samples already above level: only a real crossing counts.
      stim = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd30, 8'd45};
      for (int i = 0; i < 30; i++) stim.push_back(8'(120 + i));
      trig_level = 8'd40;
      trig_rising = 1'b1;
      run("above_start", -1);

      // Long wait so the ring wraps several times before the trigger.
      stim.delete();
      for (int i = 0; i < 60; i++) stim.push_back(8'(i % 100));
      stim.push_back(8'd200);
      for (int i = 0; i < 30; i++) stim.push_back(8'(i));
      trig_level = 8'd200;
      trig_rising = 1'b1;
      run("wrap", -1);

      for (int r = 0; r < 3; r++) begin
         logic [7:0] lvl;
         stim.delete();
         for (int i = 0; i < 40; i++) stim.push_back(8'($urandom));
         lvl = 8'($urandom_range(1, 255));
         trig_level = lvl;
         trig_rising = 1'($urandom_range(0, 1));
         if (trig_rising) begin
            stim.push_back(lvl - 8'd1);
            stim.push_back(lvl);
         end else begin
            stim.push_back(lvl);
            stim.push_back(lvl - 8'd1);
         end
         for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
         run($sformatf("rand%0d", r), -1);
      end

`ifdef CAPTURE_DECIM_EN
      dec_r = 3;
      decim = 8'd3;
      stim.delete();
      for (int i = 0; i < 256; i++) stim.push_back(8'(i));
      trig_level = 8'd100;
      trig_rising = 1'b1;
      run("decim3", -1);
      dec_r = 0;
      decim = 8'd0;
`endif

      // Arm together with rd_req in DONE: restart wins, no read.
      trig_level = 8'd20;
      trig_rising = 1'b1;
      arm = 1'b1;
      step();
      arm = 1'b0;
      j = 0;
      while (!(&dn) && j < 120) begin
         sample_in = 8'(j);
         step();
         j++;
      end
      check("arm_rd_all_done", 0, 32'(&dn), 32'd1);
      arm = 1'b1;
      rd_req = 1'b1;
      step();
      arm = 1'b0;
      rd_req = 1'b0;
      for (int g = 0; g < 3; g++) begin
         check("arm_wins_no_valid", g, 32'(rdv[g]), 32'd0);
         check("arm_wins_state", g, 32'(st[g]), (pre_of(g) == 0) ? 32'd2 : 32'd1);
      end

      // Reset in POST drops everything immediately.
      j = 0;
      while (st[0] != 3'd3 && j < 60) begin
         sample_in = 8'(j);
         step();
         j++;
      end
      check("reach_post", 0, 32'(st[0]), 32'd3);
      rst = 1'b1;
      #1;
      for (int g = 0; g < 3; g++) begin
         check("rst_post_state", g, 32'(st[g]), 32'd0);
         check("rst_post_done", g, 32'(dn[g]), 32'd0);
         check("rst_post_valid", g, 32'(rdv[g]), 32'd0);
      end
      step();
      rst = 1'b0;
      step();
      for (int g = 0; g < 3; g++) check("after_rst_idle", g, 32'(st[g]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
